// File: rtl/rotate_pkg.sv
// Shared constants and the direction enum for the 32-bit barrel rotator.
package rotate_pkg;

    localparam int ROT_WIDTH   = 32;
    localparam int ROT_SHIFT_W = 5;

    // Direction encoding matches the leftRotate port: 1 = toward MSB.
    typedef enum logic {
        ROT_RIGHT = 1'b0,
        ROT_LEFT  = 1'b1
    } rot_dir_e;

endpackage

// File: rtl/rotate_barrel.sv
// Combinational logarithmic barrel rotator.
// Stage k rotates by 2^k when shiftVar[k] is set, in the direction given by
// leftRotate. Each stage amount lies in 1..WIDTH/2, so no stage ever shifts
// by the full width and s = 0 passes the data straight through.
module rotate_barrel
    import rotate_pkg::*;
#(
    parameter  int WIDTH   = ROT_WIDTH,
    localparam int SHIFT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   inputVar,
    input  logic [SHIFT_W-1:0] shiftVar,
    input  logic               leftRotate,
    output logic [WIDTH-1:0]   rotated
);

    // Walk the stages, rotating the running value by 2^k where selected.
    always_comb begin
        logic [WIDTH-1:0] stageVal;
        stageVal = inputVar;
        for (int k = 0; k < SHIFT_W; k++) begin
            if (shiftVar[k]) begin
                if (leftRotate) begin
                    stageVal = (stageVal << (1 << k)) | (stageVal >> (WIDTH - (1 << k)));
                end else begin
                    stageVal = (stageVal >> (1 << k)) | (stageVal << (WIDTH - (1 << k)));
                end
            end
        end
        rotated = stageVal;
    end

endmodule

// File: rtl/rotate.sv
// Registered barrel rotator: one pipeline stage around rotate_barrel.
// The output register clears asynchronously while rst_n is low.
module rotate
    import rotate_pkg::*;
#(
    parameter  int WIDTH   = ROT_WIDTH,
    localparam int SHIFT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   inputVar,
    input  logic [SHIFT_W-1:0] shiftVar,
    input  logic               leftRotate,
    output logic [WIDTH-1:0]   outputVar
);

    logic [WIDTH-1:0] rotated;

    rotate_barrel #(
        .WIDTH (WIDTH)
    ) barrel (
        .inputVar   (inputVar),
        .shiftVar   (shiftVar),
        .leftRotate (leftRotate),
        .rotated    (rotated)
    );

    // Capture the rotate result every cycle; clear immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outputVar <= '0;
        end else begin
            outputVar <= rotated;
        end
    end

endmodule

// File: tb/tb_rotate.sv
// Scoreboard bench for rotate: the stimulus process pushes expected results,
// a monitor process pops and compares one cycle after each issued vector.
module tb_rotate;
    import rotate_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] inputVar;
    logic [4:0]  shiftVar;
    logic        leftRotate;
    logic [31:0] outputVar;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] expVal;
        int          id;
    } sbItem_t;

    sbItem_t sbQueue[$];
    int      issueId = 0;

    rotate dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inputVar   (inputVar),
        .shiftVar   (shiftVar),
        .leftRotate (leftRotate),
        .outputVar  (outputVar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-level reference rotate, independent of the shift formulation.
    function automatic logic [31:0] rotRef(logic [31:0] x, int s, logic left);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (left) r[(i + s) % 32] = x[i];
            else      r[i] = x[(i + s) % 32];
        end
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one vector at the falling edge and record the expected result.
    task automatic issue(logic [31:0] d, logic [4:0] s, logic left, logic [31:0] exp);
        sbItem_t it;
        @(negedge clk);
        inputVar   = d;
        shiftVar   = s;
        leftRotate = left;
        it.expVal  = exp;
        it.id      = issueId++;
        sbQueue.push_back(it);
    endtask

    // Monitor: for every vector pending at a rising edge, sample 1 ns later.
    initial begin
        sbItem_t it;
        forever begin
            @(posedge clk);
            if (rst_n && sbQueue.size() > 0) begin
                it = sbQueue.pop_front();
                #1;
                check($sformatf("vec%0d", it.id), outputVar, it.expVal);
            end
        end
    end

    // Stimulus
    initial begin
        logic [31:0] rd;
        logic [4:0]  rs;
        logic        rl;
        int          waitCycles;

        rst_n      = 1'b1;
        inputVar   = 32'hDEADBEEF;
        shiftVar   = 5'd3;
        leftRotate = 1'b1;
        #1 rst_n = 1'b0;
        #1 check("reset_immediate", outputVar, 32'h0);
        repeat (2) begin
            @(negedge clk);
            inputVar = inputVar + 32'h1111;
            @(posedge clk);
            #1 check("reset_held", outputVar, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, hand-computed.
        issue(32'h12345678, 5'd4,  1'b0, 32'h81234567);
        issue(32'h12345678, 5'd16, 1'b0, 32'h56781234);
        issue(32'h12345678, 5'd4,  1'b1, 32'h23456781);
        issue(32'h12345678, 5'd8,  1'b1, 32'h34567812);
        issue(32'h12345678, 5'd0,  1'b1, 32'h12345678);
        issue(32'h12345678, 5'd0,  1'b0, 32'h12345678);
        issue(32'h12345678, 5'd31, 1'b1, 32'h091A2B3C);
        issue(32'h12345678, 5'd31, 1'b0, 32'h2468ACF0);
        issue(32'h12345678, 5'd28, 1'b0, 32'h23456781);
        issue(32'h80000001, 5'd1,  1'b1, 32'h00000003);
        issue(32'h80000001, 5'd1,  1'b0, 32'hC0000000);
        issue(32'hF0000000, 5'd13, 1'b0, 32'h00078000);

        // Random back-to-back vectors.
        for (int i = 0; i < 16; i++) begin
            rd = $urandom;
            rs = 5'($urandom_range(0, 31));
            rl = 1'($urandom_range(0, 1));
            issue(rd, rs, rl, rotRef(rd, int'(rs), rl));
        end

        // Reset pulse mid-stream, then resume.
        @(negedge clk);
        inputVar = 32'hA5A5F00F;
        rst_n    = 1'b0;
        #1 check("reset_midstream", outputVar, 32'h0);
        @(posedge clk);
        #1 check("reset_mid_held", outputVar, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            rd = $urandom;
            rs = 5'($urandom_range(0, 31));
            rl = 1'($urandom_range(0, 1));
            issue(rd, rs, rl, rotRef(rd, int'(rs), rl));
        end

        // Drain the scoreboard with a bounded wait.
        waitCycles = 0;
        while (sbQueue.size() > 0 && waitCycles < 20) begin
            @(posedge clk);
            waitCycles++;
        end
        #2;
        if (sbQueue.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries pending, required 0", sbQueue.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
